// File: rtl/gemm_fifo_pkg.sv
// Shared types and constants for the FIFO burst reader and its output buffer.
// The buffer depth and pointer helper live here so both files agree on sizing.
package gemm_fifo_pkg;

  localparam int SKID_DEPTH = 3;
  localparam int SKID_PTR_W = 2;
  localparam int SKID_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Circular pointer advance over the SKID_DEPTH entries.
  function automatic logic [SKID_PTR_W-1:0] skid_ptr_inc(input logic [SKID_PTR_W-1:0] ptr);
    return (ptr == SKID_PTR_W'(SKID_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Command, upstream FIFO read port and downstream stream of the burst reader.
// The reader uses the master view; the surrounding environment uses the slave view.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
);
  logic                  i_start;
  logic [LEN_WIDTH-1:0]  i_burst_len;
  logic                  o_fifo_rd_en;
  logic [DATA_WIDTH-1:0] i_fifo_rd_data;
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_last;
  logic                  o_busy;
  logic                  o_done;
  logic [LEN_WIDTH-1:0]  o_beat_count;

  modport master (
    input  i_start, i_burst_len, i_fifo_rd_data, i_fifo_empty, i_ready,
    output o_fifo_rd_en, o_data, o_valid, o_last, o_busy, o_done, o_beat_count
  );

  modport slave (
    output i_start, i_burst_len, i_fifo_rd_data, i_fifo_empty, i_ready,
    input  o_fifo_rd_en, o_data, o_valid, o_last, o_busy, o_done, o_beat_count
  );
endinterface

// File: rtl/fifo_burst_reader_skid_buf.sv
// Three-entry circular output buffer between the FIFO read data and the stream.
// The head entry is presented directly; push and pop may happen in the same cycle.
module reader_skid_buf
  import gemm_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic [SKID_CNT_W-1:0] o_count
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [SKID_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SKID_CNT_W-1:0] count_q, count_d;
  logic                  do_pop;

  always_comb begin
    do_pop   = i_pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_push) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = skid_ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = skid_ptr_inc(rd_ptr_q);
    end
    count_d = count_q + SKID_CNT_W'(i_push) - SKID_CNT_W'(do_pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_head_data = mem_q[rd_ptr_q];
  assign o_count     = count_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads a commanded number of words from an upstream FIFO and streams them out
// with valid/ready, keeping reads in flight plus buffered words within three.
module fifo_burst_reader
  import gemm_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  fifo_burst_reader_if.master bus
);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] head_data;
  logic [SKID_CNT_W-1:0] buf_count;
  logic [2:0]            occupancy;
  logic                  buf_valid;
  logic                  pop;
  logic                  rd_en;
  logic                  last;

  reader_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (inflight_q),
    .i_push_data (bus.i_fifo_rd_data),
    .i_pop       (pop),
    .o_head_data (head_data),
    .o_count     (buf_count)
  );

  // Issue decision uses only registered state and the empty flag, never i_ready.
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight_q};
  assign rd_en     = (state_q == ST_RUN) && !bus.i_fifo_empty
                     && (issued_q < len_q) && (occupancy < 3'(SKID_DEPTH));
  assign buf_valid = (buf_count != '0);
  assign pop       = buf_valid && bus.i_ready;
  assign last      = buf_valid && (beat_q == len_q - LEN_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q + LEN_WIDTH'(rd_en);
    beat_d     = beat_q + LEN_WIDTH'(pop);
    inflight_d = rd_en;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          len_d    = bus.i_burst_len;
          issued_d = '0;
          beat_d   = '0;
          if (bus.i_burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (issued_q == len_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_fifo_rd_en = rd_en;
  assign bus.o_data       = head_data;
  assign bus.o_valid      = buf_valid;
  assign bus.o_last       = last;
  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_done       = done_q;
  assign bus.o_beat_count = beat_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a FIFO environment, a burst-level
// expectation model checked every cycle, and literal checks per scenario.
module tb_fifo_burst_reader;
  localparam int DW = 16;
  localparam int LW = 16;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  fifo_burst_reader_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] log_q[$];
  int          log_last[$];
  int          log_cyc[$];

  bit          m_busy = 0, m_done = 0, m_rst_prev = 1;
  int          m_len = 0, m_beats = 0, m_issued = 0, done_cnt = 0;
  bit          rd_pend = 0, rd_lost = 0, arr_v = 0;
  logic [15:0] rd_word = '0, arr_w = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs 1ns after the edge, check and advance the model at negedge.
  task automatic step(input bit st, input int len, input bit rdy, input bit rst);
    bit   allowed, mvalid, xfer, is_last, new_done, old_busy;
    logic [15:0] w;
    @(posedge i_clk);
    #1;
    i_reset         = rst;
    bus.i_start     = st;
    bus.i_burst_len = len[15:0];
    bus.i_ready     = rdy;
    if (rd_pend) begin
      bus.i_fifo_rd_data = rd_word;
      arr_v = !rd_lost;
      arr_w = rd_word;
    end else begin
      bus.i_fifo_rd_data = 16'hBAD0 ^ cyc[15:0];
      arr_v = 0;
    end
    bus.i_fifo_empty = (fifo_q.size() == 0);
    @(negedge i_clk);
    cyc++;

    mvalid  = (exp_q.size() != 0);
    allowed = m_busy && !bus.i_fifo_empty && (m_issued < m_len)
              && ((exp_q.size() + int'(arr_v)) < 3);
    chk("rd_en", int'(bus.o_fifo_rd_en), int'(allowed));
    chk("busy", int'(bus.o_busy), int'(m_busy));
    chk("done", int'(bus.o_done), int'(m_done));
    chk("beat_count", int'(bus.o_beat_count), m_beats);
    chk("valid", int'(bus.o_valid), int'(mvalid));
    if (mvalid) begin
      chk("data", int'(bus.o_data), int'(exp_q[0]));
      chk("last", int'(bus.o_last), int'(m_beats == m_len - 1));
    end else begin
      chk("last_idle", int'(bus.o_last), 0);
    end
    if (m_rst_prev) chk("reset_data", int'(bus.o_data), 0);

    // FIFO environment answers the actual strobe, including one raised during reset.
    if (bus.o_fifo_rd_en && fifo_q.size() != 0) begin
      rd_pend = 1;
      rd_word = fifo_q.pop_front();
      rd_lost = rst;
    end else begin
      rd_pend = 0;
    end

    if (rst) begin
      m_busy = 0; m_done = 0; m_beats = 0; m_issued = 0; m_len = 0;
      exp_q.delete();
      m_rst_prev = 1;
    end else begin
      m_rst_prev = 0;
      new_done = 0;
      old_busy = m_busy;
      xfer = mvalid && rdy;
      if (xfer) begin
        is_last = (m_beats == m_len - 1);
        w = exp_q.pop_front();
        log_q.push_back(w);
        log_last.push_back(int'(is_last));
        log_cyc.push_back(cyc);
        $display("beat %0d data=0x%04h last=%0d cycle=%0d", m_beats + 1, w, is_last, cyc);
        m_beats++;
        if (is_last) begin
          new_done = 1;
          m_busy = 0;
        end
      end
      if (arr_v) exp_q.push_back(arr_w);
      if (allowed) m_issued++;
      if (st && !old_busy) begin
        m_beats = 0;
        m_issued = 0;
        m_len = len;
        if (len == 0) new_done = 1;
        else m_busy = 1;
      end
      m_done = new_done;
      if (new_done) done_cnt++;
    end
    arr_v = 0;
  endtask

  // Run until the burst finishes and its done pulse has passed; mode 1 toggles ready.
  task automatic run(input int mode, input int budget);
    int n = 0;
    while (m_busy || m_done) begin
      if (n >= budget) begin
        chk("timeout", n, -1);
        return;
      end
      step(0, 0, (mode == 1) ? cyc[0] : 1'b1, 0);
      n++;
    end
  endtask

  task automatic clear_log();
    log_q.delete();
    log_last.delete();
    log_cyc.delete();
    done_cnt = 0;
  endtask

  initial begin
    logic [15:0] nxt0, nxt1;
    int li;
    i_reset            = 1;
    bus.i_start        = 0;
    bus.i_burst_len    = '0;
    bus.i_ready        = 0;
    bus.i_fifo_rd_data = '0;
    bus.i_fifo_empty   = 1;

    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_valid", int'(bus.o_valid), 0);
    chk("rst_beats", int'(bus.o_beat_count), 0);

    // Preloaded FIFO, ready held high.
    clear_log();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(16'(i));
    step(1, 8, 1, 0);
    run(0, 200);
    step(0, 0, 1, 0);
    chk("t1_count", log_q.size(), 8);
    for (int k = 0; k < 8 && k < log_q.size(); k++) chk("t1_word", int'(log_q[k]), k + 1);
    li = -1;
    foreach (log_last[k]) if (log_last[k] == 1) li = k;
    chk("t1_last_idx", li, 7);
    if (log_cyc.size() == 8) chk("t1_consecutive", log_cyc[7] - log_cyc[0], 7);
    chk("t1_beats", int'(bus.o_beat_count), 8);
    chk("t1_done_cnt", done_cnt, 1);

    // Ready toggling every cycle.
    clear_log();
    for (int i = 0; i < 8; i++) fifo_q.push_back(16'h0011 + 16'(i));
    step(1, 8, 1, 0);
    run(1, 300);
    chk("t2_count", log_q.size(), 8);
    for (int k = 0; k < 8 && k < log_q.size(); k++) chk("t2_word", int'(log_q[k]), 16'h0011 + k);

    // FIFO runs dry mid-burst, refilled ten cycles later.
    clear_log();
    for (int i = 0; i < 3; i++) fifo_q.push_back(16'h0021 + 16'(i));
    step(1, 6, 1, 0);
    repeat (10) step(0, 0, 1, 0);
    chk("t3_partial", log_q.size(), 3);
    chk("t3_stall_busy", int'(bus.o_busy), 1);
    for (int i = 3; i < 6; i++) fifo_q.push_back(16'h0021 + 16'(i));
    run(0, 200);
    chk("t3_count", log_q.size(), 6);
    for (int k = 0; k < 6 && k < log_q.size(); k++) chk("t3_word", int'(log_q[k]), 16'h0021 + k);
    if (log_last.size() == 6) chk("t3_last6", log_last[5], 1);
    chk("t3_beats", int'(bus.o_beat_count), 6);

    // Zero-length command, then a start issued while running.
    clear_log();
    fifo_q.push_back(16'h0031);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t4_done_pulse", int'(bus.o_done), 1);
    chk("t4_idle", int'(bus.o_busy), 0);
    step(0, 0, 1, 0);
    chk("t4_done_low", int'(bus.o_done), 0);
    chk("t4_no_reads", fifo_q.size(), 1);
    chk("t4_beats0", int'(bus.o_beat_count), 0);
    chk("t4_done_cnt", done_cnt, 1);
    fifo_q.push_back(16'h0032);
    clear_log();
    step(1, 2, 1, 0);
    step(1, 5, 1, 0);
    run(0, 100);
    chk("t4_run_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t4_w0", int'(log_q[0]), 16'h0031);
      chk("t4_w1", int'(log_q[1]), 16'h0032);
    end
    chk("t4_beats2", int'(bus.o_beat_count), 2);

    // Reset after four of eight beats, then a fresh two-beat burst.
    clear_log();
    for (int i = 0; i < 8; i++) fifo_q.push_back(16'h0041 + 16'(i));
    step(1, 8, 1, 0);
    for (int n = 0; m_beats < 4; n++) begin
      if (n > 50) begin
        chk("t5_timeout", n, -1);
        break;
      end
      step(0, 0, 1, 0);
    end
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    chk("t5_rst_busy", int'(bus.o_busy), 0);
    chk("t5_rst_valid", int'(bus.o_valid), 0);
    chk("t5_rst_last", int'(bus.o_last), 0);
    chk("t5_rst_done", int'(bus.o_done), 0);
    chk("t5_rst_beats", int'(bus.o_beat_count), 0);
    chk("t5_rst_data", int'(bus.o_data), 0);
    chk("t5_rst_rd_en", int'(bus.o_fifo_rd_en), 0);
    for (int i = 0; i < 4; i++) fifo_q.push_back(16'h0051 + 16'(i));
    nxt0 = fifo_q[0];
    nxt1 = fifo_q[1];
    clear_log();
    step(1, 2, 1, 0);
    run(0, 100);
    chk("t5_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t5_w0", int'(log_q[0]), int'(nxt0));
      chk("t5_w1", int'(log_q[1]), int'(nxt1));
    end
    step(0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
